// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioning path.
package btn_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int unsigned CNT_W_DEF           = 20;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_e;

  // Registered output payload: debounced level plus press/release strobes.
  typedef struct packed {
    logic level;
    logic pulse;
    logic rel;
  } btn_out_t;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous board inputs.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/btn_conditioner.sv
// Debounces a raw push-button into a clean level plus one-cycle press/release strobes.
// Optional press counter output enabled by defining BTN_PRESS_COUNT_EN.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
`ifdef BTN_PRESS_COUNT_EN
  ,
  parameter int unsigned PCNT_W          = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_raw,
  output logic              btn_level,
  output logic              btn_pulse,
  output logic              btn_release
`ifdef BTN_PRESS_COUNT_EN
  ,
  output logic [PCNT_W-1:0] press_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             btn_sync;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  btn_out_t         out_q, out_d;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (btn_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Strobes default low every cycle; a new level is accepted only after a full stable run.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    out_d.pulse = 1'b0;
    out_d.rel   = 1'b0;

    unique case (state_q)
      IDLE_LOW: begin
        if (btn_sync) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!btn_sync) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE_HIGH;
          cnt_d       = '0;
          out_d.level = 1'b1;
          out_d.pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!btn_sync) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (btn_sync) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE_LOW;
          cnt_d       = '0;
          out_d.level = 1'b0;
          out_d.rel   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign btn_level   = out_q.level;
  assign btn_pulse   = out_q.pulse;
  assign btn_release = out_q.rel;

`ifdef BTN_PRESS_COUNT_EN
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;

  // Advances on the same edge that raises btn_pulse; wraps naturally.
  always_comb begin
    pcnt_d = pcnt_q;
    if (out_d.pulse) begin
      pcnt_d = pcnt_q + PCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  assign press_count = pcnt_q;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with DEBOUNCE_CYCLES=4 (PCNT_W=2 when BTN_PRESS_COUNT_EN).
module tb_btn_conditioner;

  localparam int unsigned DEB     = 4;
  localparam int unsigned TB_CW   = 3;
  localparam int unsigned LAT     = DEB + 2;
`ifdef BTN_PRESS_COUNT_EN
  localparam int unsigned TB_PCW  = 2;
`endif

  typedef struct {
    int unsigned cyc;
    bit          rel;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_raw = 1'b0;
  logic btn_level, btn_pulse, btn_release;
`ifdef BTN_PRESS_COUNT_EN
  logic [TB_PCW-1:0] press_count;
  int unsigned exp_pc = 0;
`endif

  int unsigned edge_n = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (TB_CW)
`ifdef BTN_PRESS_COUNT_EN
    ,
    .PCNT_W          (TB_PCW)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_pulse   (btn_pulse),
    .btn_release (btn_release)
`ifdef BTN_PRESS_COUNT_EN
    ,
    .press_count (press_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the button at a negedge; an accepted change is expected LAT edges later.
  task automatic drive_expect(input logic v);
    ev_t ev;
    btn_raw = v;
    ev.cyc  = edge_n + LAT;
    ev.rel  = !v;
    exp_q.push_back(ev);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn_raw = 1'b0;
    wait_cycles(2);
    reset = 1'b0;
  endtask

  // Monitor samples just after each active edge and retires scoreboard entries.
  always @(posedge clk) begin
    ev_t ev;
    #1;
`ifdef BTN_PRESS_COUNT_EN
    if (reset) exp_pc = 0;
`endif
    if (!reset && exp_q.size() != 0 && edge_n > exp_q[0].cyc) begin
      ev = exp_q.pop_front();
      check("missed_strobe", edge_n, ev.cyc);
    end
    if (!reset && (btn_pulse || btn_release)) begin
      check("strobe_exclusive", 32'(btn_pulse & btn_release), 0);
      if (exp_q.size() == 0) begin
        check("spurious_strobe", 1, 0);
      end else begin
        ev = exp_q.pop_front();
        check("strobe_cycle", edge_n, ev.cyc);
        check("strobe_kind_release", 32'(btn_release), 32'(ev.rel));
        check("level_at_strobe", 32'(btn_level), 32'(!ev.rel));
`ifdef BTN_PRESS_COUNT_EN
        if (btn_pulse) begin
          exp_pc++;
          check("press_count", 32'(press_count), exp_pc % (1 << TB_PCW));
        end
`endif
      end
    end
  end

  initial begin
    int unsigned m;
    ev_t ev;

    // Reset state
    wait_cycles(3);
    check("reset_level", 32'(btn_level), 0);
    check("reset_pulse", 32'(btn_pulse), 0);
    check("reset_release", 32'(btn_release), 0);
    reset = 1'b0;
    wait_cycles(2);

    // Clean press held: one pulse only
    drive_expect(1'b1);
    wait_cycles(20);
    check("held_level", 32'(btn_level), 1);

    // Clean release
    drive_expect(1'b0);
    wait_cycles(15);
    check("released_level", 32'(btn_level), 0);

    // Bounce 1,0,1,0 (2 cycles each) then steady 1
    for (int i = 0; i < 4; i++) begin
      btn_raw = (i % 2 == 0);
      wait_cycles(2);
    end
    check("bounce_level", 32'(btn_level), 0);
    drive_expect(1'b1);
    wait_cycles(15);
    check("bounce_settled_level", 32'(btn_level), 1);
    drive_expect(1'b0);
    wait_cycles(15);

    // Reset while in WAIT_HIGH with count 2
    btn_raw = 1'b1;
    wait_cycles(4);
    reset = 1'b1;
    wait_cycles(1);
    check("midreset_level", 32'(btn_level), 0);
    check("midreset_pulse", 32'(btn_pulse), 0);
    check("midreset_release", 32'(btn_release), 0);
    reset = 1'b0;
    m = edge_n;
    ev.cyc = m + LAT;
    ev.rel = 1'b0;
    exp_q.push_back(ev);
    wait_cycles(LAT - 1);
    check("midreset_no_early_level", 32'(btn_level), 0);
    wait_cycles(10);
    check("midreset_redebounced_level", 32'(btn_level), 1);
    drive_expect(1'b0);
    wait_cycles(15);

    // Glitch of 3 synchronized cycles
    btn_raw = 1'b1;
    wait_cycles(3);
    btn_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_cycles(1);
      check("glitch_level", 32'(btn_level), 0);
    end
    wait_cycles(5);

    // Five clean presses from a fresh reset
    do_reset();
    wait_cycles(2);
    for (int i = 0; i < 5; i++) begin
      drive_expect(1'b1);
      wait_cycles(12);
      drive_expect(1'b0);
      wait_cycles(12);
    end

    wait_cycles(10);
    check("pending_strobes", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time bound in case anything stalls.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
